// File: rtl/wb_stage.sv
// RV32I write-back stage: load extraction, 32x32 register file with bypassed
// registered read ports, EX forwarding taps and the 64-bit retired-instruction counter.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_wb,
  input  logic [2:0]  ld_code_wb,
  input  logic [4:0]  rd_adr_wb,
  input  logic [31:0] rd_data_wb,
  input  logic        wbk_rd_reg_wb,
  input  logic [31:0] ld_data_wb,
  input  logic        inst_retire_wb,
  input  logic        stall,
  input  logic        rst_pipe_wb,
  input  logic [4:0]  rs1_adr_id,
  input  logic [4:0]  rs2_adr_id,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] wbk_data_wb,
  output logic        wbk_en_fwd,
  output logic [31:0] wbk_data_wb2,
  output logic [4:0]  rd_adr_wb2,
  output logic        wbk_en_wb2,
  input  logic [1:0]  csr_instret_we,
  input  logic [31:0] csr_instret_wdata,
  output logic [63:0] instret
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  logic [31:0] rf_q [32];
  logic [31:0] rs1_d, rs1_q;
  logic [31:0] rs2_d, rs2_q;
  logic [31:0] wbk_data_wb2_q;
  logic [4:0]  rd_adr_wb2_q;
  logic        wbk_en_wb2_q;
  logic [63:0] instret_d, instret_q;

  always_comb begin
    ld_byte = ld_data_wb[7:0];
    case (rd_data_wb[1:0])
      2'd0: ld_byte = ld_data_wb[7:0];
      2'd1: ld_byte = ld_data_wb[15:8];
      2'd2: ld_byte = ld_data_wb[23:16];
      2'd3: ld_byte = ld_data_wb[31:24];
      default: ld_byte = ld_data_wb[7:0];
    endcase
  end

  assign ld_half = rd_data_wb[1] ? ld_data_wb[31:16] : ld_data_wb[15:0];

  always_comb begin
    ld_ext = '0;
    case (ld_code_wb)
      3'b000: ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001: ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010: ld_ext = ld_data_wb;
      3'b100: ld_ext = {24'd0, ld_byte};
      3'b101: ld_ext = {16'd0, ld_half};
      default: ld_ext = '0;
    endcase
  end

  assign wbk_data_wb = cmd_ld_wb ? ld_ext : rd_data_wb;
  assign wbk_en_fwd  = wbk_rd_reg_wb & (rd_adr_wb != 5'd0) & ~rst_pipe_wb;

  // x0 is never written because wbk_en_fwd excludes rd == 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wbk_en_fwd) begin
      rf_q[rd_adr_wb] <= wbk_data_wb;
    end
  end

  always_comb begin
    rs1_d = rf_q[rs1_adr_id];
    if (rs1_adr_id == 5'd0)
      rs1_d = '0;
    else if (wbk_en_fwd && (rd_adr_wb == rs1_adr_id))
      rs1_d = wbk_data_wb;
  end

  always_comb begin
    rs2_d = rf_q[rs2_adr_id];
    if (rs2_adr_id == 5'd0)
      rs2_d = '0;
    else if (wbk_en_fwd && (rd_adr_wb == rs2_adr_id))
      rs2_d = wbk_data_wb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (!stall) begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbk_data_wb2_q <= '0;
      rd_adr_wb2_q   <= '0;
      wbk_en_wb2_q   <= 1'b0;
    end else if (rst_pipe_wb) begin
      wbk_data_wb2_q <= '0;
      rd_adr_wb2_q   <= '0;
      wbk_en_wb2_q   <= 1'b0;
    end else begin
      wbk_data_wb2_q <= wbk_data_wb;
      rd_adr_wb2_q   <= rd_adr_wb;
      wbk_en_wb2_q   <= wbk_en_fwd;
    end
  end

  // A CSR write to either half takes priority over the retire increment
  always_comb begin
    instret_d = instret_q;
    if (|csr_instret_we) begin
      if (csr_instret_we[0]) instret_d[31:0]  = csr_instret_wdata;
      if (csr_instret_we[1]) instret_d[63:32] = csr_instret_wdata;
    end else if (inst_retire_wb && !stall && !rst_pipe_wb) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign rs1_data_ex  = rs1_q;
  assign rs2_data_ex  = rs2_q;
  assign wbk_data_wb2 = wbk_data_wb2_q;
  assign rd_adr_wb2   = rd_adr_wb2_q;
  assign wbk_en_wb2   = wbk_en_wb2_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed stimulus queues expected values,
// a negedge monitor pops and compares them in the cycle they are due.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_ld_wb;
  logic [2:0]  ld_code_wb;
  logic [4:0]  rd_adr_wb;
  logic [31:0] rd_data_wb;
  logic        wbk_rd_reg_wb;
  logic [31:0] ld_data_wb;
  logic        inst_retire_wb;
  logic        stall;
  logic        rst_pipe_wb;
  logic [4:0]  rs1_adr_id, rs2_adr_id;
  logic [31:0] rs1_data_ex, rs2_data_ex;
  logic [31:0] wbk_data_wb;
  logic        wbk_en_fwd;
  logic [31:0] wbk_data_wb2;
  logic [4:0]  rd_adr_wb2;
  logic        wbk_en_wb2;
  logic [1:0]  csr_instret_we;
  logic [31:0] csr_instret_wdata;
  logic [63:0] instret;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .cmd_ld_wb(cmd_ld_wb), .ld_code_wb(ld_code_wb),
    .rd_adr_wb(rd_adr_wb), .rd_data_wb(rd_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
    .ld_data_wb(ld_data_wb), .inst_retire_wb(inst_retire_wb), .stall(stall),
    .rst_pipe_wb(rst_pipe_wb), .rs1_adr_id(rs1_adr_id), .rs2_adr_id(rs2_adr_id),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .wbk_data_wb(wbk_data_wb),
    .wbk_en_fwd(wbk_en_fwd), .wbk_data_wb2(wbk_data_wb2), .rd_adr_wb2(rd_adr_wb2),
    .wbk_en_wb2(wbk_en_wb2), .csr_instret_we(csr_instret_we),
    .csr_instret_wdata(csr_instret_wdata), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam int unsigned S_RS1 = 0, S_RS2 = 1, S_WBD = 2, S_WEN = 3,
                          S_WB2D = 4, S_WB2A = 5, S_WB2E = 6, S_IRET = 7;

  typedef struct {
    int unsigned cyc;
    int unsigned sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t        sbq[$];
  int unsigned cyc_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [63:0] sig(input int unsigned s);
    case (s)
      S_RS1:  return {32'd0, rs1_data_ex};
      S_RS2:  return {32'd0, rs2_data_ex};
      S_WBD:  return {32'd0, wbk_data_wb};
      S_WEN:  return {63'd0, wbk_en_fwd};
      S_WB2D: return {32'd0, wbk_data_wb2};
      S_WB2A: return {59'd0, rd_adr_wb2};
      S_WB2E: return {63'd0, wbk_en_wb2};
      S_IRET: return instret;
      default: return '0;
    endcase
  endfunction

  // Monitor: compare every entry due in the current cycle
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc_cnt) begin
        n_checks++;
        if (sig(sbq[i].sel) !== sbq[i].exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)",
                   sbq[i].name, sig(sbq[i].sel), sbq[i].exp, cyc_cnt);
        end
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc_cnt) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: never sampled, expected 0x%h", sbq[i].name, sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  task automatic exp_now(input int unsigned s, input logic [63:0] v, input string n);
    chk_t c;
    c.cyc = cyc_cnt; c.sel = s; c.exp = v; c.name = n;
    sbq.push_back(c);
  endtask

  task automatic exp_next(input int unsigned s, input logic [63:0] v, input string n);
    chk_t c;
    c.cyc = cyc_cnt + 1; c.sel = s; c.exp = v; c.name = n;
    sbq.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_ld_wb = 0; ld_code_wb = 3'b010; rd_adr_wb = 0; rd_data_wb = 0;
    wbk_rd_reg_wb = 0; ld_data_wb = 0; inst_retire_wb = 0; stall = 0;
    rst_pipe_wb = 0; rs1_adr_id = 0; rs2_adr_id = 0;
    csr_instret_we = 0; csr_instret_wdata = 0;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    wbk_rd_reg_wb = 1; rd_adr_wb = rd; rd_data_wb = d; cmd_ld_wb = 0;
  endtask

  task automatic load_chk(input logic [2:0] code, input logic [31:0] adr,
                          input logic [31:0] e, input string n);
    idle();
    cmd_ld_wb = 1; ld_code_wb = code; rd_data_wb = adr; ld_data_wb = 32'h80FF_7F01;
    exp_now(S_WBD, {32'd0, e}, n);
    step();
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    exp_now(S_RS1, 0, "reset_rs1");
    exp_now(S_RS2, 0, "reset_rs2");
    exp_now(S_WB2D, 0, "reset_wb2_data");
    exp_now(S_WB2A, 0, "reset_wb2_adr");
    exp_now(S_WB2E, 0, "reset_wb2_en");
    exp_now(S_IRET, 0, "reset_instret");

    for (int i = 1; i < 32; i++) begin
      idle();
      rs1_adr_id = 5'(i); rs2_adr_id = 5'(32 - i);
      exp_next(S_RS1, 0, "reset_rf_rs1");
      exp_next(S_RS2, 0, "reset_rf_rs2");
      step();
    end

    // write x5, read back from array next cycle
    idle(); wr(5, 32'h1234_5678);
    exp_now(S_WBD, 64'h1234_5678, "wr_x5_data");
    exp_now(S_WEN, 1, "wr_x5_en");
    exp_next(S_WB2D, 64'h1234_5678, "wb2_data_x5");
    exp_next(S_WB2A, 5, "wb2_adr_x5");
    exp_next(S_WB2E, 1, "wb2_en_x5");
    step();
    idle(); rs1_adr_id = 5;
    exp_next(S_RS1, 64'h1234_5678, "rd_x5");
    step();

    load_chk(3'b000, 32'h0000_1003, 32'hFFFF_FF80, "lb_ofs3");
    load_chk(3'b100, 32'h0000_1003, 32'h0000_0080, "lbu_ofs3");
    load_chk(3'b000, 32'h0000_1000, 32'h0000_0001, "lb_ofs0");
    load_chk(3'b001, 32'h0000_1002, 32'hFFFF_80FF, "lh_ofs2");
    load_chk(3'b001, 32'h0000_1003, 32'hFFFF_80FF, "lh_ofs3_bit0_ignored");
    load_chk(3'b101, 32'h0000_1000, 32'h0000_7F01, "lhu_ofs0");
    load_chk(3'b010, 32'h0000_1002, 32'h80FF_7F01, "lw");
    load_chk(3'b011, 32'h0000_1000, 32'h0000_0000, "bad_code");

    // write to x0 must be dropped, including the bypass path
    idle(); wr(0, 32'hDEAD_BEEF);
    exp_now(S_WBD, 64'hDEAD_BEEF, "x0_wbk_data");
    exp_now(S_WEN, 0, "x0_wbk_en");
    exp_next(S_RS1, 0, "x0_bypass");
    step();
    idle();
    exp_next(S_RS1, 0, "x0_read");
    step();

    // same-cycle write/read bypass, then hold through stall
    idle(); wr(7, 32'hA5A5_A5A5); rs1_adr_id = 7; rs2_adr_id = 5;
    exp_next(S_RS1, 64'hA5A5_A5A5, "bypass_x7");
    exp_next(S_RS2, 64'h1234_5678, "rs2_x5");
    step();
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; rs1_adr_id = 5; rs2_adr_id = 7;
      if (i == 1) wr(8, 32'h0BAD_F00D);
      exp_next(S_RS1, 64'hA5A5_A5A5, "stall_hold_rs1");
      exp_next(S_RS2, 64'h1234_5678, "stall_hold_rs2");
      step();
    end
    idle(); rs1_adr_id = 5; rs2_adr_id = 8;
    exp_next(S_RS1, 64'h1234_5678, "post_stall_rs1");
    exp_next(S_RS2, 64'h0BAD_F00D, "write_during_stall");
    step();

    // flush with write and retire
    idle(); wr(9, 32'h9999_9999); rst_pipe_wb = 1; inst_retire_wb = 1;
    exp_now(S_WEN, 0, "flush_en");
    exp_next(S_WB2E, 0, "flush_wb2_en");
    exp_next(S_WB2D, 0, "flush_wb2_data");
    exp_next(S_WB2A, 0, "flush_wb2_adr");
    exp_next(S_IRET, 0, "flush_no_retire");
    step();
    idle(); rs1_adr_id = 9;
    exp_next(S_RS1, 0, "flush_x9_unwritten");
    step();

    idle(); inst_retire_wb = 1;
    exp_next(S_IRET, 1, "retire_one");
    step();
    idle(); inst_retire_wb = 1; stall = 1;
    exp_next(S_IRET, 1, "retire_stalled");
    step();

    idle(); csr_instret_we = 2'b01; csr_instret_wdata = 32'hFFFF_FFFF;
    exp_next(S_IRET, 64'h0000_0000_FFFF_FFFF, "csr_low_preset");
    step();
    idle(); inst_retire_wb = 1;
    exp_next(S_IRET, 64'h0000_0001_0000_0000, "retire_carry");
    step();
    idle(); inst_retire_wb = 1; csr_instret_we = 2'b01; csr_instret_wdata = 0;
    exp_next(S_IRET, 64'h0000_0001_0000_0000, "csr_low_blocks_retire");
    step();
    idle(); csr_instret_we = 2'b10; csr_instret_wdata = 32'h0000_00AB;
    exp_next(S_IRET, 64'h0000_00AB_0000_0000, "csr_high_only");
    step();
    idle(); csr_instret_we = 2'b11; csr_instret_wdata = 32'hFFFF_FFFF;
    exp_next(S_IRET, 64'hFFFF_FFFF_FFFF_FFFF, "csr_both");
    step();
    idle(); inst_retire_wb = 1;
    exp_next(S_IRET, 0, "instret_wrap");
    step();

    // asynchronous reset in mid-cycle with a write pending
    idle(); inst_retire_wb = 1; rs1_adr_id = 5;
    step();
    idle(); wr(10, 32'h1010_1010); inst_retire_wb = 1; rs1_adr_id = 5;
    #1 rst_n = 0;
    exp_now(S_IRET, 0, "async_rst_instret");
    exp_now(S_RS1, 0, "async_rst_rs1");
    exp_now(S_WB2E, 0, "async_rst_wb2_en");
    step();
    idle(); rst_n = 1; rs1_adr_id = 10; rs2_adr_id = 5;
    exp_next(S_RS1, 0, "async_rst_x10");
    exp_next(S_RS2, 0, "async_rst_x5");
    step();

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the RV32I pipeline, directly downstream of the memory access stage. Takes the MA-to-WB pipeline registers and the raw 32-bit load word, extracts and sign/zero-extends load results, and writes the 32x32 integer register file it owns. Serves the ID stage with two registered read ports (with write-through bypass), provides current and one-cycle-old write-back values for EX forwarding, and maintains the 64-bit retired-instruction counter.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_ld_wb  in  1  instruction in WB is a load
- ld_code_wb  in  3  funct3 of load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd_adr_wb  in  5  destination register
- rd_data_wb  in  32  ALU result, or effective address for loads
- wbk_rd_reg_wb  in  1  instruction writes rd
- ld_data_wb  in  32  raw load word from data RAM / IO
- inst_retire_wb  in  1  valid instruction retiring this cycle
- stall  in  1  pipeline stall
- rst_pipe_wb  in  1  pipeline flush for WB
- rs1_adr_id, rs2_adr_id  in  5 each  ID read addresses
- rs1_data_ex, rs2_data_ex  out  32 each  registered read data
- wbk_data_wb  out  32  final write-back value (combinational)
- wbk_en_fwd  out  1  write qualifier for forwarding (combinational)
- wbk_data_wb2  out  32  previous cycle write-back value
- rd_adr_wb2  out  5  previous cycle rd
- wbk_en_wb2  out  1  previous cycle write qualifier
- csr_instret_we  in  2  bit0 writes instret[31:0], bit1 writes instret[63:32]
- csr_instret_wdata  in  32  CSR write data
- instret  out  64  retired-instruction count

## Operation
- Load extraction, ofs = rd_data_wb[1:0]: LB/LBU pick byte ofs, sign-/zero-extend; LH/LHU pick halfword rd_data_wb[1] (bit0 ignored), sign-/zero-extend; LW passes ld_data_wb; any other code gives 0.
- wbk_data_wb = cmd_ld_wb ? extracted value : rd_data_wb.
- wbk_en_fwd = wbk_rd_reg_wb & (rd_adr_wb != 0) & ~rst_pipe_wb.
- Register file write at posedge when wbk_en_fwd; independent of stall (MA already masks cancelled writes). x0 never written, always reads 0.
- Read ports: at posedge, when ~stall, rsN_data_ex <= (wbk_en_fwd & rd_adr_wb == rsN_adr_id) ? wbk_data_wb : rf[rsN_adr_id]; rsN_adr_id == 0 gives 0. During stall both hold.
- wb2 registers: every posedge load wbk_data_wb, rd_adr_wb, wbk_en_fwd; rst_pipe_wb clears all three to 0.
- instret: +1 at posedge when inst_retire_wb & ~stall & ~rst_pipe_wb; wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 with carry from low to high word. Any csr_instret_we bit set: written halves take csr_instret_wdata, unwritten halves hold, increment suppressed that cycle.

## Timing
- Reset: all 32 registers, rs1_data_ex, rs2_data_ex, wbk_data_wb2, rd_adr_wb2, wbk_en_wb2, instret = 0.
- wbk_data_wb / wbk_en_fwd: zero-latency from inputs.
- Write-to-read: write in cycle N is visible on rsN_data_ex after edge N via bypass; read issued in N+1 sees it from the array.
- Read latency 1 cycle; values held for whole stall, update on first non-stall edge.
- Simultaneous flush and write: write suppressed, wb2 cleared, no retire count.
- Reset asserted mid-operation clears everything asynchronously; no partial writes survive.

## Test plan
- Reset, read x1..x31 -> all 0; write x5=0x1234_5678, read x5 next cycle -> 0x1234_5678.
- LB with ld_data_wb=0x80FF_7F01, rd_data_wb[1:0]=3 -> 0xFFFF_FF80; LBU same -> 0x0000_0080; LH ofs=2 -> 0xFFFF_80FF; LHU ofs=0 -> 0x0000_7F01.
- Write rd=x0 data 0xDEAD_BEEF, wbk_rd_reg_wb=1 -> x0 reads 0, wbk_en_fwd=0.
- Same-cycle write x7=0xA5A5_A5A5 and read rs1=x7 -> rs1_data_ex=0xA5A5_A5A5 after edge; stall 3 cycles with new rs1 -> value held.
- rst_pipe_wb with write x9 and inst_retire_wb=1 -> x9 unchanged, wbk_en_wb2=0, instret unchanged.
- instret preset via CSR to 0x0000_0000_FFFF_FFFF, one retire -> 0x0000_0001_0000_0000; write low=0 with retire same cycle -> 0x0000_0001_0000_0000, no increment.
